// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 block sequencer.
package sha256_pkg;

  localparam int unsigned BLK_W = 512;
  localparam int unsigned DIG_W = 256;

  localparam logic [DIG_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPad,
    StIssue,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/sha256_pad_unit.sv
// Combinational builder of one padded 512-bit block from the word buffer.
// Byte p of the message stream maps to block blk, word j, byte k with p = 64*blk + 4*j + k.
module sha256_pad_unit
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic [BLK_W-1:0] msg_buf,
  input  logic [LEN_W:0]   blk,
  input  logic [LEN_W-1:0] len,
  input  logic             last_blk,
  output logic [BLK_W-1:0] block
);

  localparam int unsigned PW = LEN_W + 8;

  logic [63:0]   len_bits;
  logic [PW-1:0] blk_base;
  logic [PW-1:0] len_ext;
  logic [PW-1:0] pos;

  always_comb begin
    len_bits = 64'(len) << 3;
    blk_base = PW'(blk) << 6;
    len_ext  = PW'(len);
    pos      = '0;
    block    = '0;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 4; k++) begin
        pos = blk_base + PW'(4 * j + k);
        if (pos < len_ext) begin
          block[BLK_W-1-32*j-8*k -: 8] = msg_buf[BLK_W-1-32*j-8*k -: 8];
        end else if (pos == len_ext) begin
          block[BLK_W-1-32*j-8*k -: 8] = 8'h80;
        end else if (last_blk && j >= 14) begin
          block[BLK_W-1-32*j-8*k -: 8] = len_bits[63-8*(4*(j-14)+k) -: 8];
        end
      end
    end
  end

endmodule

// File: rtl/sha256_blk_ctrl.sv
// SHA-256 message sequencer: buffers words, pads, issues blocks and chains the hash.
// Optional core timeout enabled by defining SHA256_BLK_CTRL_TIMEOUT_EN.
module sha256_blk_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BLK_W-1:0] core_m_in,
  output logic [DIG_W-1:0] core_h_in,
  output logic             core_start,
  input  logic [DIG_W-1:0] core_h_out,
  input  logic             core_done,
  output logic [DIG_W-1:0] digest,
  output logic             digest_valid,
  output logic             busy,
  output logic             err
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e state_q, state_d;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   blk_q;
  logic [4:0]       wcnt_q;
  logic [LEN_W-1:0] gw_q;
  logic [31:0]      buf_q [16];
  logic [DIG_W-1:0] h_q;
  logic [BLK_W-1:0] m_q;
  logic [DIG_W-1:0] hin_q;
  logic [DIG_W-1:0] digest_q;

  logic [LEN_W:0]   len_ext;
  logic [LEN_W:0]   nblk;
  logic [LEN_W-1:0] nw;
  logic             last_blk;
  logic             hs;
  logic             load_end;
  logic             tmo_hit;
  logic [BLK_W-1:0] msg_flat;
  logic [BLK_W-1:0] padded;

  assign len_ext  = {1'b0, len_q};
  // 8 length bytes plus the 0x80 marker decide whether an extra block is needed
  assign nblk     = ((len_ext + (LEN_W+1)'(8)) >> 6) + (LEN_W+1)'(1);
  assign nw       = LEN_W'((len_ext + (LEN_W+1)'(3)) >> 2);
  assign last_blk = (blk_q == nblk - (LEN_W+1)'(1));
  assign hs       = in_valid && in_ready;
  // Leave LOAD in the same cycle the final word of the block is taken
  assign load_end = (wcnt_q == 5'd16) || (gw_q == nw) ||
                    (hs && ((wcnt_q == 5'd15) || (gw_q + LEN_W'(1) == nw)));

  always_comb begin
    msg_flat = '0;
    for (int i = 0; i < 16; i++) begin
      msg_flat[BLK_W-1-32*i -: 32] = buf_q[i];
    end
  end

  sha256_pad_unit #(
    .LEN_W (LEN_W)
  ) u_pad (
    .msg_buf  (msg_flat),
    .blk      (blk_q),
    .len      (len_q),
    .last_blk (last_blk),
    .block    (padded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (msg_start) state_d = StLoad;
      StLoad:  if (load_end) state_d = StPad;
      StPad:   state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (core_done) begin
          state_d = last_blk ? StDone : StLoad;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == StLoad) && (gw_q < nw) && (wcnt_q < 5'd16);
    core_start   = (state_q == StIssue);
    digest_valid = (state_q == StDone);
    busy         = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      blk_q    <= '0;
      wcnt_q   <= '0;
      gw_q     <= '0;
      h_q      <= SHA256_IV;
      m_q      <= '0;
      hin_q    <= SHA256_IV;
      digest_q <= '0;
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (msg_start) begin
            len_q  <= msg_len;
            h_q    <= SHA256_IV;
            blk_q  <= '0;
            wcnt_q <= '0;
            gw_q   <= '0;
          end
        end
        StLoad: begin
          if (hs) begin
            buf_q[wcnt_q[3:0]] <= in_data;
            wcnt_q             <= wcnt_q + 5'd1;
            gw_q               <= gw_q + LEN_W'(1);
          end
        end
        StPad: begin
          m_q   <= padded;
          hin_q <= h_q;
        end
        StWait: begin
          if (core_done) begin
            h_q    <= core_h_out;
            blk_q  <= blk_q + (LEN_W+1)'(1);
            wcnt_q <= '0;
            // Load the digest now so it is already valid during the DONE pulse
            if (last_blk) digest_q <= core_h_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_m_in = m_q;
  assign core_h_in = hin_q;
  assign digest    = digest_q;

`ifdef SHA256_BLK_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  // tmo_q counts cycles since core_start; TIMEOUT_CYC-1 in WAIT means err shows at +TIMEOUT_CYC
  assign tmo_hit = (state_q == StWait) && !core_done && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        tmo_q <= TMO_W'(1);
      end else if (state_q == StWait) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
